marker_decoder: RTL and testbench
=================================

MARKER_DECODER -- requirements
Module: marker_decoder

Interface
REQ-001 Parameter CMD_PREFIX, default 8'h1C, SHALL be the upper byte that identifies a legal command word.
REQ-002 Parameter COMMA, default 16'hBC3C, SHALL be the idle word; it is valid only with K-flags 2'b11.
REQ-003 XCVR_CLK  input  1: the only clock; all logic is sampled on its rising edge.
REQ-004 XCVR_RESETN  input  1: reset, asynchronous, active-low.
REQ-005 DATA_FROM_RX  input  16: received word, one per clock.
REQ-006 KCHAR_FROM_RX  input  2: per-byte K flags; 11 = comma, 10 = command, 00 = data word.
REQ-007 CNT_CLEAR  input  1: synchronous clear of ERR_COUNT.
REQ-008 CLOCK_MARKER, EVENT_MARKER, LOOPBACK_MARKER, DIAG_MARKER, TIMEOUT_MARKER, RETRANS_MARKER  output  1 each: one-cycle good-marker pulses.
REQ-009 RETRANS_SEQ  output  4: sequence number; valid while RETRANS_MARKER=1 and held afterwards.
REQ-010 DCS_REQ, UNDEF_CMD  output  1 each: one-cycle pulses for non-marker commands.
REQ-011 ERR_MARKER, ERR_RETRANS, ERR_ILLEGAL  output  1 each: one-cycle error pulses.
REQ-012 ERR_COUNT  output  8: saturating count of error pulses.

Function
REQ-013 All outputs SHALL be registered; every pulse SHALL assert on the clock after the word that completes or breaks a sequence is sampled.
REQ-014 The decoder SHALL have exactly three states: IDLE, WAIT_N (holds the expected complement word and a marker id), and WAIT_SEQ.
REQ-015 In IDLE, with K=10 and CMD_PREFIX upper byte, the decoder SHALL decode words as follows:
 - 1C11 -> WAIT_N(1CEE, clock)
 - 1C10 -> WAIT_N(1CEF, event)
 - 1C12 -> WAIT_N(1CED, loopback)
 - 1C13 -> WAIT_N(1CEC, diag)
 - 1C15 -> WAIT_N(1CEA, retrans)
 - 1C14 -> TIMEOUT_MARKER pulse, stay IDLE
 - 1C00 -> DCS_REQ pulse
 - any complement word (1CEE, 1CEF, 1CED, 1CEC, 1CEA) -> ERR_MARKER
 - any other 1Cxx -> UNDEF_CMD.
REQ-016 In IDLE, the decoder SHALL raise ERR_ILLEGAL for K=10 with a wrong upper byte, for K=01, or for K=11 with a word other than COMMA; it SHALL ignore K=00 data words and COMMA.
REQ-017 In WAIT_N, if the word equals the expected complement with K=10, the decoder SHALL:
 - for non-retrans markers, pulse the matching marker output and go to IDLE;
 - for retrans, go to WAIT_SEQ.
REQ-018 In WAIT_N, any other word (including COMMA or a repeat of the first word) SHALL cause an ERR_MARKER pulse and a return to IDLE; the offending word SHALL be discarded and not re-decoded.
REQ-019 In WAIT_SEQ, a K=00 word whose four nibbles are all equal SHALL pulse RETRANS_MARKER and load RETRANS_SEQ with DATA_FROM_RX[3:0].
REQ-020 In WAIT_SEQ, any other word SHALL pulse ERR_RETRANS, leave RETRANS_SEQ unchanged, and return to IDLE.
REQ-021 At most one pulse output SHALL be high in any cycle.
REQ-022 ERR_COUNT SHALL increment by 1 on each ERR_MARKER, ERR_RETRANS or ERR_ILLEGAL pulse and SHALL saturate at 255.
REQ-023 When CNT_CLEAR and an error pulse occur in the same cycle, CNT_CLEAR SHALL win and ERR_COUNT SHALL become 0.

Reset
REQ-024 Asserting XCVR_RESETN low SHALL immediately force the state to IDLE, all pulses to 0, RETRANS_SEQ to 0 and ERR_COUNT to 0, including in the middle of a sequence.
REQ-025 After reset is released, a partial sequence interrupted by reset SHALL NOT produce any marker or error pulse.

Verification
REQ-026 Input 1C11/10, 1CEE/10, BC3C/11 -> exactly one CLOCK_MARKER pulse, one cycle after 1CEE is sampled; no errors.
REQ-027 Input 1C15/10, 1CEA/10, 7777/00 -> RETRANS_MARKER pulse with RETRANS_SEQ=7; input 1C15, 1CEA, 7077/00 -> ERR_RETRANS and RETRANS_SEQ stays 7.
REQ-028 Input 1C11, 1CEF -> ERR_MARKER; input 1C10, 1C10, BC3C -> exactly one ERR_MARKER; input 1CEF alone -> ERR_MARKER; ERR_COUNT=3.
REQ-029 Input 1C14 -> TIMEOUT_MARKER; 1C00 -> DCS_REQ; 1C20 -> UNDEF_CMD; 1234/10 -> ERR_ILLEGAL; 1C15, 1CEA, BC3C -> ERR_RETRANS.
REQ-030 Inject 300 errors -> ERR_COUNT=255; then CNT_CLEAR coinciding with an error -> ERR_COUNT=0.
REQ-031 Input 1C12, assert XCVR_RESETN low for 2 cycles, release, then 1CED -> ERR_MARKER only, and no LOOPBACK_MARKER.

Source files
------------

// File: rtl/marker_decoder.sv
// Transceiver marker decoder: turns command/complement word pairs into one-cycle marker pulses,
// flags malformed sequences and keeps a saturating error count.
module marker_decoder #(
    parameter logic [7:0]  CMD_PREFIX = 8'h1C,
    parameter logic [15:0] COMMA      = 16'hBC3C
) (
    input  logic        XCVR_CLK,
    input  logic        XCVR_RESETN,
    input  logic [15:0] DATA_FROM_RX,
    input  logic [1:0]  KCHAR_FROM_RX,
    input  logic        CNT_CLEAR,
    output logic        CLOCK_MARKER,
    output logic        EVENT_MARKER,
    output logic        LOOPBACK_MARKER,
    output logic        DIAG_MARKER,
    output logic        TIMEOUT_MARKER,
    output logic        RETRANS_MARKER,
    output logic [3:0]  RETRANS_SEQ,
    output logic        DCS_REQ,
    output logic        UNDEF_CMD,
    output logic        ERR_MARKER,
    output logic        ERR_RETRANS,
    output logic        ERR_ILLEGAL,
    output logic [7:0]  ERR_COUNT
);

    typedef enum logic [1:0] {StIdle, StWaitN, StWaitSeq} state_e;
    typedef enum logic [2:0] {MkClock, MkEvent, MkLoopback, MkDiag, MkRetrans} marker_e;

    localparam int unsigned PClock    = 0;
    localparam int unsigned PEvent    = 1;
    localparam int unsigned PLoopback = 2;
    localparam int unsigned PDiag     = 3;
    localparam int unsigned PTimeout  = 4;
    localparam int unsigned PRetrans  = 5;
    localparam int unsigned PDcs      = 6;
    localparam int unsigned PUndef    = 7;
    localparam int unsigned PErrMark  = 8;
    localparam int unsigned PErrRetr  = 9;
    localparam int unsigned PErrIll   = 10;

    state_e      state_q, state_d;
    marker_e     marker_q, marker_d;
    logic [7:0]  expect_q, expect_d;
    logic [3:0]  seq_q, seq_d;
    logic [10:0] pulse_q, pulse_d;
    logic [7:0]  count_q, count_d;

    logic       upper_ok;
    logic       cmd_ok;
    logic [7:0] low;
    logic       nibbles_eq;

    assign low        = DATA_FROM_RX[7:0];
    assign upper_ok   = DATA_FROM_RX[15:8] == CMD_PREFIX;
    assign cmd_ok     = (KCHAR_FROM_RX == 2'b10) && upper_ok;
    assign nibbles_eq = (DATA_FROM_RX[15:12] == DATA_FROM_RX[11:8]) &&
                        (DATA_FROM_RX[11:8] == DATA_FROM_RX[7:4]) &&
                        (DATA_FROM_RX[7:4] == DATA_FROM_RX[3:0]);

    always_comb begin
        state_d  = state_q;
        marker_d = marker_q;
        expect_d = expect_q;
        seq_d    = seq_q;
        pulse_d  = '0;
        unique case (state_q)
            StIdle: begin
                unique case (KCHAR_FROM_RX)
                    2'b10: begin
                        if (!upper_ok) begin
                            pulse_d[PErrIll] = 1'b1;
                        end else begin
                            // Openers store the complement low byte expected next.
                            case (low)
                                8'h11: begin state_d = StWaitN; marker_d = MkClock;    expect_d = 8'hEE; end
                                8'h10: begin state_d = StWaitN; marker_d = MkEvent;    expect_d = 8'hEF; end
                                8'h12: begin state_d = StWaitN; marker_d = MkLoopback; expect_d = 8'hED; end
                                8'h13: begin state_d = StWaitN; marker_d = MkDiag;     expect_d = 8'hEC; end
                                8'h15: begin state_d = StWaitN; marker_d = MkRetrans;  expect_d = 8'hEA; end
                                8'h14: pulse_d[PTimeout] = 1'b1;
                                8'h00: pulse_d[PDcs] = 1'b1;
                                8'hEE, 8'hEF, 8'hED, 8'hEC, 8'hEA: pulse_d[PErrMark] = 1'b1;
                                default: pulse_d[PUndef] = 1'b1;
                            endcase
                        end
                    end
                    2'b01: pulse_d[PErrIll] = 1'b1;
                    2'b11: if (DATA_FROM_RX != COMMA) pulse_d[PErrIll] = 1'b1;
                    default: ;
                endcase
            end
            StWaitN: begin
                state_d = StIdle;
                if (cmd_ok && low == expect_q) begin
                    case (marker_q)
                        MkClock:    pulse_d[PClock] = 1'b1;
                        MkEvent:    pulse_d[PEvent] = 1'b1;
                        MkLoopback: pulse_d[PLoopback] = 1'b1;
                        MkDiag:     pulse_d[PDiag] = 1'b1;
                        default:    state_d = StWaitSeq;
                    endcase
                end else begin
                    pulse_d[PErrMark] = 1'b1;
                end
            end
            StWaitSeq: begin
                state_d = StIdle;
                if (KCHAR_FROM_RX == 2'b00 && nibbles_eq) begin
                    pulse_d[PRetrans] = 1'b1;
                    seq_d             = DATA_FROM_RX[3:0];
                end else begin
                    pulse_d[PErrRetr] = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Count moves on the same edge that raises the error pulse, so clear wins on a tie.
    always_comb begin
        count_d = count_q;
        if (CNT_CLEAR) begin
            count_d = '0;
        end else if ((pulse_d[PErrMark] || pulse_d[PErrRetr] || pulse_d[PErrIll]) &&
                     count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge XCVR_CLK or negedge XCVR_RESETN) begin
        if (!XCVR_RESETN) begin
            state_q  <= StIdle;
            marker_q <= MkClock;
            expect_q <= '0;
            seq_q    <= '0;
            pulse_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            marker_q <= marker_d;
            expect_q <= expect_d;
            seq_q    <= seq_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
        end
    end

    assign CLOCK_MARKER    = pulse_q[PClock];
    assign EVENT_MARKER    = pulse_q[PEvent];
    assign LOOPBACK_MARKER = pulse_q[PLoopback];
    assign DIAG_MARKER     = pulse_q[PDiag];
    assign TIMEOUT_MARKER  = pulse_q[PTimeout];
    assign RETRANS_MARKER  = pulse_q[PRetrans];
    assign DCS_REQ         = pulse_q[PDcs];
    assign UNDEF_CMD       = pulse_q[PUndef];
    assign ERR_MARKER      = pulse_q[PErrMark];
    assign ERR_RETRANS     = pulse_q[PErrRetr];
    assign ERR_ILLEGAL     = pulse_q[PErrIll];
    assign RETRANS_SEQ     = seq_q;
    assign ERR_COUNT       = count_q;

endmodule

// File: tb/tb_marker_decoder.sv
// Randomized bench for marker_decoder: each sampled word is replayed into a queue-based
// reference model and every output is compared one step after the word is sampled.
module tb_marker_decoder;

    logic        XCVR_CLK = 1'b0;
    logic        XCVR_RESETN;
    logic [15:0] DATA_FROM_RX;
    logic [1:0]  KCHAR_FROM_RX;
    logic        CNT_CLEAR;
    logic        CLOCK_MARKER, EVENT_MARKER, LOOPBACK_MARKER, DIAG_MARKER;
    logic        TIMEOUT_MARKER, RETRANS_MARKER, DCS_REQ, UNDEF_CMD;
    logic        ERR_MARKER, ERR_RETRANS, ERR_ILLEGAL;
    logic [3:0]  RETRANS_SEQ;
    logic [7:0]  ERR_COUNT;

    marker_decoder dut (
        .XCVR_CLK        (XCVR_CLK),
        .XCVR_RESETN     (XCVR_RESETN),
        .DATA_FROM_RX    (DATA_FROM_RX),
        .KCHAR_FROM_RX   (KCHAR_FROM_RX),
        .CNT_CLEAR       (CNT_CLEAR),
        .CLOCK_MARKER    (CLOCK_MARKER),
        .EVENT_MARKER    (EVENT_MARKER),
        .LOOPBACK_MARKER (LOOPBACK_MARKER),
        .DIAG_MARKER     (DIAG_MARKER),
        .TIMEOUT_MARKER  (TIMEOUT_MARKER),
        .RETRANS_MARKER  (RETRANS_MARKER),
        .RETRANS_SEQ     (RETRANS_SEQ),
        .DCS_REQ         (DCS_REQ),
        .UNDEF_CMD       (UNDEF_CMD),
        .ERR_MARKER      (ERR_MARKER),
        .ERR_RETRANS     (ERR_RETRANS),
        .ERR_ILLEGAL     (ERR_ILLEGAL),
        .ERR_COUNT       (ERR_COUNT)
    );

    always #5 XCVR_CLK = ~XCVR_CLK;

    int total = 0;
    int bad   = 0;

    // Bit order of the pulse vector: clock, event, loopback, diag, timeout, retrans,
    // dcs, undef, err_marker, err_retrans, err_illegal (bit 0 .. bit 10).
    logic [7:0]  openers [5] = '{8'h11, 8'h10, 8'h12, 8'h13, 8'h15};
    int          open_bit[5] = '{0, 1, 2, 3, 5};

    logic [15:0] m_q[$];
    logic [10:0] m_pulse;
    int          m_count;
    logic [3:0]  m_seq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] dut_pulses();
        return {ERR_ILLEGAL, ERR_RETRANS, ERR_MARKER, UNDEF_CMD, DCS_REQ, RETRANS_MARKER,
                TIMEOUT_MARKER, DIAG_MARKER, LOOPBACK_MARKER, EVENT_MARKER, CLOCK_MARKER};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pulse = '0;
        m_count = 0;
        m_seq   = '0;
    endtask

    // Reference: the queue holds the words accepted so far in the current sequence.
    task automatic model_step(input logic [15:0] w, input logic [1:0] k, input logic clr);
        int hit;
        logic is_cmd;
        logic [15:0] first;
        m_pulse = '0;
        is_cmd  = (k == 2'b10) && (w[15:8] == 8'h1C);
        if (m_q.size() == 0) begin
            if (k == 2'b10 && !is_cmd) m_pulse[10] = 1'b1;
            else if (k == 2'b01) m_pulse[10] = 1'b1;
            else if (k == 2'b11 && w != 16'hBC3C) m_pulse[10] = 1'b1;
            else if (is_cmd) begin
                hit = -1;
                for (int i = 0; i < 5; i++) if (w[7:0] == openers[i]) hit = i;
                if (hit >= 0) m_q.push_back(w);
                else if (w[7:0] == 8'h14) m_pulse[4] = 1'b1;
                else if (w[7:0] == 8'h00) m_pulse[6] = 1'b1;
                else begin
                    for (int i = 0; i < 5; i++) if (w[7:0] == ~openers[i]) hit = i;
                    if (hit >= 0) m_pulse[8] = 1'b1;
                    else m_pulse[7] = 1'b1;
                end
            end
        end else if (m_q.size() == 1) begin
            first = m_q[0];
            if (is_cmd && w[7:0] == ~first[7:0]) begin
                if (first[7:0] == 8'h15) m_q.push_back(w);
                else begin
                    for (int i = 0; i < 4; i++) if (first[7:0] == openers[i]) m_pulse[open_bit[i]] = 1'b1;
                    m_q.delete();
                end
            end else begin
                m_pulse[8] = 1'b1;
                m_q.delete();
            end
        end else begin
            if (k == 2'b00 && w[15:12] == w[3:0] && w[11:8] == w[3:0] && w[7:4] == w[3:0]) begin
                m_pulse[5] = 1'b1;
                m_seq      = w[3:0];
            end else begin
                m_pulse[9] = 1'b1;
            end
            m_q.delete();
        end
        if (clr) m_count = 0;
        else if ((m_pulse[8] || m_pulse[9] || m_pulse[10]) && m_count < 255) m_count++;
    endtask

    task automatic check_all();
        check("pulses", {21'd0, dut_pulses()}, {21'd0, m_pulse});
        check("err_count", {24'd0, ERR_COUNT}, m_count);
        check("retrans_seq", {28'd0, RETRANS_SEQ}, {28'd0, m_seq});
        check("one_hot", $countones(dut_pulses()) <= 1, 1);
    endtask

    task automatic step(input logic [15:0] w, input logic [1:0] k, input logic clr);
        @(negedge XCVR_CLK);
        DATA_FROM_RX  = w;
        KCHAR_FROM_RX = k;
        CNT_CLEAR     = clr;
        @(posedge XCVR_CLK);
        #1;
        model_step(w, k, clr);
        check_all();
    endtask

    task automatic pulse_reset(input int cycles);
        @(negedge XCVR_CLK);
        XCVR_RESETN   = 1'b0;
        DATA_FROM_RX  = '0;
        KCHAR_FROM_RX = 2'b00;
        CNT_CLEAR     = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (cycles) @(negedge XCVR_CLK);
        XCVR_RESETN = 1'b1;
    endtask

    task automatic random_step();
        logic [15:0] w;
        logic [1:0]  k;
        logic [3:0]  n;
        logic [15:0] first;
        k = 2'b10;
        if (m_q.size() == 1 && $urandom_range(0, 2) != 0) begin
            first = m_q[0];
            w = {8'h1C, ~first[7:0]};
        end else begin
            case ($urandom_range(0, 7))
                0: w = {8'h1C, openers[$urandom_range(0, 4)]};
                1: w = {8'h1C, ~openers[$urandom_range(0, 4)]};
                2: begin
                    n = 4'($urandom_range(0, 15));
                    w = {n, n, n, n};
                    if ($urandom_range(0, 3) == 0) w[11:8] = ~n;
                    k = 2'b00;
                end
                3: begin w = 16'hBC3C; k = 2'b11; end
                4: w = {8'h1C, 8'($urandom)};
                5: begin w = 16'($urandom); k = 2'($urandom); end
                6: w = $urandom_range(0, 1) ? 16'h1C14 : 16'h1C00;
                default: begin w = 16'($urandom); k = 2'b00; end
            endcase
        end
        step(w, k, $urandom_range(0, 49) == 0);
    endtask

    initial begin
        XCVR_RESETN   = 1'b1;
        DATA_FROM_RX  = '0;
        KCHAR_FROM_RX = 2'b00;
        CNT_CLEAR     = 1'b0;
        #2 XCVR_RESETN = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge XCVR_CLK);
        XCVR_RESETN = 1'b1;

        // Clock marker with trailing comma.
        step(16'h1C11, 2'b10, 0);
        step(16'h1CEE, 2'b10, 0);
        check("clock_marker", CLOCK_MARKER, 1);
        step(16'hBC3C, 2'b11, 0);
        // Retransmit good then bad sequence number.
        step(16'h1C15, 2'b10, 0);
        step(16'h1CEA, 2'b10, 0);
        step(16'h7777, 2'b00, 0);
        check("retrans_seq7", RETRANS_SEQ, 7);
        step(16'h1C15, 2'b10, 0);
        step(16'h1CEA, 2'b10, 0);
        step(16'h7077, 2'b00, 0);
        check("err_retrans", ERR_RETRANS, 1);
        check("retrans_seq_hold", RETRANS_SEQ, 7);

        pulse_reset(1);
        step(16'h1C11, 2'b10, 0);
        step(16'h1CEF, 2'b10, 0);
        step(16'h1C10, 2'b10, 0);
        step(16'h1C10, 2'b10, 0);
        step(16'hBC3C, 2'b11, 0);
        step(16'h1CEF, 2'b10, 0);
        check("err_count3", ERR_COUNT, 3);

        step(16'h1C14, 2'b10, 0);
        check("timeout", TIMEOUT_MARKER, 1);
        step(16'h1C00, 2'b10, 0);
        check("dcs", DCS_REQ, 1);
        step(16'h1C20, 2'b10, 0);
        check("undef", UNDEF_CMD, 1);
        step(16'h1234, 2'b10, 0);
        check("illegal", ERR_ILLEGAL, 1);
        step(16'h1C15, 2'b10, 0);
        step(16'h1CEA, 2'b10, 0);
        step(16'hBC3C, 2'b11, 0);
        check("retrans_comma", ERR_RETRANS, 1);

        // Saturation, then clear racing an error.
        for (int i = 0; i < 300; i++) step(16'h1234, 2'b10, 0);
        check("count_sat", ERR_COUNT, 255);
        step(16'h1234, 2'b10, 1);
        step(16'h0000, 2'b00, 0);
        check("count_clr", ERR_COUNT, 0);

        // Reset in the middle of a loopback sequence.
        step(16'h1C12, 2'b10, 0);
        pulse_reset(2);
        step(16'h1CED, 2'b10, 0);
        check("post_reset_err", ERR_MARKER, 1);
        check("post_reset_noloop", LOOPBACK_MARKER, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset($urandom_range(1, 3));
            else random_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
